// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with flush and a saturating upstream-stall counter.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry so in_ready is registered.
module pipe_stage #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      stall_cnt
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_stall;
  logic             w_accept;
  logic             w_release;
  assign w_accept  = in_valid && in_ready;
  assign w_release = r_valid && out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign stall_cnt = r_stall;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall <= '0;
    else if (in_valid && !in_ready && !flush && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end
`ifdef PIPE_STAGE_SKID_EN
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_skid_data;
  assign in_ready  = r_in_ready;
  assign occupancy = {r_skid_valid, r_valid && !r_skid_valid};
  // in_ready is precomputed as "not going to hold two entries", so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_data       <= BUBBLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_data       <= BUBBLE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE;
      r_in_ready   <= 1'b1;
    end else if (r_skid_valid) begin
      if (out_ready) begin
        r_data       <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_data  <= BUBBLE;
        r_in_ready   <= 1'b1;
      end
    end else if (w_accept && r_valid && !out_ready) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_in_ready   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (w_release) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end
  end
`else
  assign in_ready  = !r_valid || out_ready;
  assign occupancy = {1'b0, r_valid};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (w_release) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: scoreboard bench for pipe_stage (32-bit zero-bubble and 128-bit patterned-bubble instances).
`timescale 1ns/1ps
module tb_pipe_stage;
  localparam int W  = 32;
  localparam int WW = 128;
  localparam logic [WW-1:0] WBUB = {4{32'h0B0B_CAFE}};
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [WW-1:0] in_wide = '0;
  logic in_ready, out_valid, in_ready_w, out_valid_w;
  logic [W-1:0] out_data;
  logic [WW-1:0] out_wide;
  logic [1:0] occupancy, occ_w;
  logic [15:0] stall_cnt, stall_w;
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] q[$];
  logic [WW-1:0] wq[$];
  int m_stall = 0;
  bit m_ready;
  always #5 clk = ~clk;
  pipe_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt));
  pipe_stage #(.WIDTH(WW), .BUBBLE(WBUB)) dut_w (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_wide),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_wide),
    .occupancy(occ_w), .stall_cnt(stall_w));
  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Monitor: compare DUT against the model's held entries, then retire the head on release.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      wq.delete();
      m_stall = 0;
    end
    m_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
    chk("in_ready", in_ready, m_ready);
    chk("in_ready_w", in_ready_w, m_ready);
    chk("occupancy", occupancy, q.size());
    chk("occupancy_w", occ_w, wq.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_valid_w", out_valid_w, wq.size() != 0);
    chk("out_data", out_data, q.size() != 0 ? q[0] : '0);
    chk("out_data_w", out_wide, wq.size() != 0 ? wq[0] : WBUB);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("stall_cnt_w", stall_w, m_stall);
    if (!reset && !flush && in_valid && !m_ready && m_stall < 65535) m_stall++;
    if (!reset && !flush && out_ready && q.size() != 0) begin
      void'(q.pop_front());
      void'(wq.pop_front());
    end
  end
  // Feeder: every accepted stimulus is queued as an expected output; flush/reset discard everything.
  always @(negedge clk) begin
    #1;
    if (reset || flush) begin
      q.delete();
      wq.delete();
    end else if (in_valid && m_ready) begin
      q.push_back(in_data);
      wq.push_back(in_wide);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    in_wide   = {$urandom, $urandom, $urandom, $urandom};
    out_ready = r;
    flush     = f;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    drive(0, '0, 0, 0);
    step();
    reset = 1'b0;
  endtask
  initial begin
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (2) step();
    reset = 1'b0;
    drive(1, 32'h7, 0, 0);
    step();
    chk("held_before_reset", out_valid, 1'b1);
    #1;
    reset = 1'b1;
    drive(1, 32'hDEAD_BEEF, 0, 0);
    #1;
    chk("async_reset_valid", out_valid, 1'b0);
    chk("async_reset_data", out_data, '0);
    chk("async_reset_stall", stall_cnt, '0);
    step();
    chk("reset_edge_valid", out_valid, 1'b0);
    chk("reset_edge_data", out_data, '0);
    chk("reset_edge_stall", stall_cnt, '0);
    reset = 1'b0;
    drive(0, '0, 1, 0);
    repeat (2) step();
    chk("no_ghost_after_reset", out_valid, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, 1, 0);
      step();
      chk("stream", {out_valid, out_data}, {1'b1, 32'(k)});
    end
    drive(0, '0, 1, 0);
    step();
    chk("stream_drained", out_valid, 1'b0);
    pulse_reset();
    drive(1, 32'hA1, 0, 0);
    step();
    drive(1, 32'hA2, 0, 0);
    step();
    chk("bp_occupancy", occupancy, 2'(CAP));
    chk("bp_in_ready", in_ready, 1'b0);
    repeat (5) step();
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_stall", stall_cnt, 16'd5);
`else
    chk("bp_stall", stall_cnt, 16'd6);
`endif
    chk("bp_head_a1", out_data, 32'hA1);
    drive(1, 32'hA2, 1, 0);
    step();
    chk("bp_head_a2", {occupancy, out_data}, {2'd1, 32'hA2});
    drive(0, '0, 1, 0);
    step();
    chk("bp_empty", {occupancy, out_valid}, {2'd0, 1'b0});
    drive(1, 32'h11, 0, 0);
    step();
    drive(1, 32'h22, 0, 0);
    step();
    chk("flush_pre_occ", occupancy, 2'(CAP));
    drive(1, 32'h55, 1, 1);
    step();
    chk("flush_state", {occupancy, out_valid, out_data}, {2'd0, 1'b0, 32'h0});
    drive(0, '0, 1, 0);
    repeat (3) step();
    chk("flush_no_55", out_valid, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, $urandom, $urandom_range(2) != 0, $urandom_range(39) == 0);
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 1'b0;
    drive(0, '0, 1, 0);
    repeat (4) step();
    chk("random_drained", occupancy, 2'd0);
    pulse_reset();
    drive(1, 32'hC0DE, 0, 0);
    repeat (70000) step();
    chk("stall_saturated", stall_cnt, 16'hFFFF);
    chk("held_unchanged", out_data, 32'hC0DE);
    repeat (10) step();
    chk("stall_stays", stall_cnt, 16'hFFFF);
    drive(0, '0, 1, 0);
    repeat (3) step();
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
